// File: rtl/dmem_arbiter.sv
// Arbitrates the single data memory between the core load/store path and a DMA/debug master.
// One memory transaction at a time over a req/ack handshake, with DMA anti-starvation and an access timeout.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_mode,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_done,
    output logic        core_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [2:0] MODE_WORD = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_D} state_t;

    state_t      state, state_n;
    logic [SW-1:0] starve_cnt, starve_cnt_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;

    logic        mem_req_n, mem_we_n;
    logic [2:0]  mem_mode_n;
    logic [31:0] mem_addr_n, mem_wdata_n;
    logic [31:0] core_rdata_n, dma_rdata_n;
    logic        core_done_n, dma_done_n, bus_err_n;
    logic        grant_dma, timed_out;
    logic [31:0] resp_data;

    // Stall drops in the done cycle so the hazard logic releases exactly when data is valid.
    assign core_stall = core_req & ~core_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_mode   <= 3'b000;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            core_rdata <= 32'h0;
            dma_rdata  <= 32'h0;
            core_done  <= 1'b0;
            dma_done   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
            tmo_cnt    <= tmo_cnt_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_mode   <= mem_mode_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            core_rdata <= core_rdata_n;
            dma_rdata  <= dma_rdata_n;
            core_done  <= core_done_n;
            dma_done   <= dma_done_n;
            bus_err    <= bus_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        starve_cnt_n = starve_cnt;
        tmo_cnt_n    = tmo_cnt;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_mode_n   = mem_mode;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        core_rdata_n = core_rdata;
        dma_rdata_n  = dma_rdata;
        core_done_n  = 1'b0;
        dma_done_n   = 1'b0;
        bus_err_n    = 1'b0;
        grant_dma    = dma_req & (~core_req | (starve_cnt == SW'(STARVE_MAX)));
        timed_out    = (tmo_cnt == TW'(TIMEOUT - 1));
        resp_data    = (mem_ack && !mem_we) ? mem_rdata : 32'h0;

        case (state)
            IDLE: begin
                if (core_req || dma_req) begin
                    mem_req_n = 1'b1;
                    tmo_cnt_n = '0;
                    if (grant_dma) begin
                        state_n      = BUSY_D;
                        starve_cnt_n = '0;
                        mem_we_n     = dma_we;
                        mem_mode_n   = MODE_WORD;
                        mem_addr_n   = dma_addr;
                        mem_wdata_n  = dma_wdata;
                    end else begin
                        state_n     = BUSY_C;
                        mem_we_n    = core_we;
                        mem_mode_n  = core_mode;
                        mem_addr_n  = core_addr;
                        mem_wdata_n = core_wdata;
                        if (dma_req && (starve_cnt != SW'(STARVE_MAX)))
                            starve_cnt_n = starve_cnt + SW'(1);
                    end
                end
            end
            BUSY_C, BUSY_D: begin
                // An ack arriving on the timeout cycle still wins: resp_data is valid, no error.
                if (mem_ack || timed_out) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    bus_err_n = ~mem_ack;
                    if (state == BUSY_C) begin
                        core_done_n  = 1'b1;
                        core_rdata_n = resp_data;
                    end else begin
                        dma_done_n  = 1'b1;
                        dma_rdata_n = resp_data;
                    end
                end else begin
                    tmo_cnt_n = tmo_cnt + TW'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reactive memory model, done-pulse scoreboard,
// directed latency/timeout/reset/starvation cases plus a few random transactions.
module tb_dmem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic        clk, rst;
    logic        core_req, core_we;
    logic [2:0]  core_mode;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_done, core_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_done;
    logic        mem_req, mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, bus_err;

    dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_mode(core_mode),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_done(core_done), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .bus_err(bus_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory model: acks ack_lat cycles after mem_req rises; idle_ack injects a stray ack
    int          ack_lat  = 1000;
    logic [31:0] rd_value = 32'h0;
    logic        idle_ack = 1'b0;
    int          age      = 0;
    logic        req_prev = 1'b0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    end

    always @(negedge clk) begin
        if (mem_req) age = req_prev ? age + 1 : 0;
        req_prev  = mem_req;
        mem_ack   = (mem_req && age == ack_lat) || idle_ack;
        mem_rdata = mem_ack ? rd_value : 32'hBAD0_BAD0;
    end

    // scoreboard: {bus_err, rdata} expected per completion
    logic [32:0] core_exp_q[$];
    logic [32:0] dma_exp_q[$];
    logic        order_q[$];     // 0 = core, 1 = dma
    int          done_cnt = 0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (core_done) begin
            done_cnt++;
            order_q.push_back(1'b0);
            if (core_exp_q.size() == 0) check_eq("core_done_unexpected", 32'(core_done), 32'h0);
            else begin
                e = core_exp_q.pop_front();
                check_eq("core_rdata", core_rdata, e[31:0]);
                check_eq("core_bus_err", 32'(bus_err), 32'(e[32]));
            end
        end
        if (dma_done) begin
            done_cnt++;
            order_q.push_back(1'b1);
            if (dma_exp_q.size() == 0) check_eq("dma_done_unexpected", 32'(dma_done), 32'h0);
            else begin
                e = dma_exp_q.pop_front();
                check_eq("dma_rdata", dma_rdata, e[31:0]);
                check_eq("dma_bus_err", 32'(bus_err), 32'(e[32]));
            end
        end
    end

    // driver: one transaction from one master, measured from the cycle req is raised
    task automatic txn(input bit is_dma, input bit we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input logic [31:0] rdval,
                       output int stall_n, output int req_at, output int done_at);
        logic        err;
        logic [31:0] ed;
        logic [2:0]  emode;
        logic        dn;
        err   = (lat > TIMEOUT - 1);
        ed    = (err || we) ? 32'h0 : rdval;
        emode = is_dma ? 3'b010 : mode;
        ack_lat  = lat;
        rd_value = rdval;
        if (is_dma) begin
            dma_exp_q.push_back({err, ed});
            dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            core_exp_q.push_back({err, ed});
            core_we = we; core_mode = mode; core_addr = addr; core_wdata = wdata; core_req = 1'b1;
        end
        stall_n = 0; req_at = -1; done_at = -1;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin @(negedge clk); #1; end else #1;
            if (core_stall) stall_n++;
            if (mem_req && req_at < 0) req_at = c;
            if (mem_req) begin
                check_eq("mem_we", 32'(mem_we), 32'(we));
                check_eq("mem_mode", 32'(mem_mode), 32'(emode));
                check_eq("mem_addr", mem_addr, addr);
                check_eq("mem_wdata", mem_wdata, wdata);
            end
            dn = is_dma ? dma_done : core_done;
            if (dn) begin
                done_at = c;
                break;
            end
        end
        core_req = 1'b0;
        dma_req  = 1'b0;
        if (done_at < 0) check_eq("txn_no_done", 32'h0, 32'h1);
        check_eq("req_latency", 32'(req_at), 32'd1);
        check_eq("done_latency", 32'(done_at - req_at), err ? 32'(TIMEOUT) : 32'(lat + 1));
        ack_lat = 1000;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
    endtask

    int          s, r, d;
    logic        exp_order[10];
    logic [31:0] last_rd;

    initial begin
        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_mode = 3'b000; core_addr = 32'h0; core_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        idle_cycles(3);
        check_eq("rst_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_core_done", 32'(core_done), 32'h0);
        check_eq("rst_dma_done", 32'(dma_done), 32'h0);
        check_eq("rst_bus_err", 32'(bus_err), 32'h0);
        check_eq("rst_core_rdata", core_rdata, 32'h0);
        check_eq("rst_dma_rdata", dma_rdata, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_core_stall", 32'(core_stall), 32'h0);
        rst = 1'b0;
        idle_cycles(2);

        // core load, ack two cycles after mem_req
        txn(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 2, 32'hDEAD_BEEF, s, r, d);
        check_eq("load_stall_cycles", 32'(s), 32'd4);
        idle_cycles(1);

        // DMA write: word mode forced
        txn(1'b1, 1'b1, 3'b000, 32'h0000_0100, 32'h5A5A_5A5A, 3, 32'h1111_2222, s, r, d);
        check_eq("dma_stall_cycles", 32'(s), 32'd0);
        idle_cycles(1);

        // core store returns zero rdata
        txn(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hCAFE_F00D, 1, 32'h7777_7777, s, r, d);
        idle_cycles(1);

        // no ack: timeout abort
        txn(1'b0, 1'b0, 3'b100, 32'h0000_0080, 32'h0, 1000, 32'h3333_3333, s, r, d);
        idle_cycles(1);

        // ack on the exact timeout cycle
        txn(1'b0, 1'b0, 3'b010, 32'h0000_0084, 32'h0, TIMEOUT - 1, 32'h4444_5555, s, r, d);
        idle_cycles(1);

        // DMA read
        txn(1'b1, 1'b0, 3'b000, 32'h0000_0200, 32'h0, 4, 32'h0BAD_CAFE, s, r, d);
        idle_cycles(1);

        // stray ack while idle must not complete anything
        last_rd  = 32'h0BAD_CAFE;
        rd_value = 32'hFFFF_0000;
        idle_ack = 1'b1;
        idle_cycles(1);
        idle_ack = 1'b0;
        idle_cycles(2);
        check_eq("idle_ack_mem_req", 32'(mem_req), 32'h0);
        check_eq("idle_ack_dma_rdata", dma_rdata, last_rd);
        check_eq("idle_ack_core_done", 32'(core_done), 32'h0);

        // reset one cycle after mem_req rises: access dropped, no done
        ack_lat = 1000;
        core_we = 1'b0; core_mode = 3'b010; core_addr = 32'h0000_0300; core_req = 1'b1;
        for (int c = 0; c < 10 && !mem_req; c++) begin @(negedge clk); #1; end
        check_eq("rst_test_mem_req_up", 32'(mem_req), 32'h1);
        idle_cycles(1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mid_core_done", 32'(core_done), 32'h0);
        core_req = 1'b0;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(3);
        check_eq("post_rst_core_done", 32'(core_done), 32'h0);
        txn(1'b0, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 2, 32'h6789_ABCD, s, r, d);
        idle_cycles(1);

        // both masters held: C,C,C,C,D repeating
        ack_lat  = 1;
        rd_value = 32'h1234_5678;
        for (int i = 0; i < 10; i++) exp_order[i] = (i % 5 == 4);
        for (int i = 0; i < 8; i++) core_exp_q.push_back({1'b0, 32'h1234_5678});
        for (int i = 0; i < 2; i++) dma_exp_q.push_back({1'b0, 32'h1234_5678});
        order_q.delete();
        done_cnt = 0;
        core_we = 1'b0; core_addr = 32'h0000_0400;
        dma_we = 1'b0; dma_addr = 32'h0000_0500;
        core_req = 1'b1; dma_req = 1'b1;
        for (int c = 0; c < 200 && done_cnt < 10; c++) begin @(negedge clk); #1; end
        core_req = 1'b0; dma_req = 1'b0;
        ack_lat = 1000;
        check_eq("starve_done_count", 32'(done_cnt), 32'd10);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("grant_order_%0d", i),
                     (i < order_q.size()) ? 32'(order_q[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        idle_cycles(2);

        // random single-master transactions
        for (int i = 0; i < 6; i++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom_range(0, 5), $urandom, s, r, d);
            idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(2);
        check_eq("core_exp_q_empty", 32'(core_exp_q.size()), 32'd0);
        check_eq("dma_exp_q_empty", 32'(dma_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
